// File: rtl/maxpool_window_sched.sv
// maxpool_window_sched: reduces each WINDOW-beat FP32 window to its max
// using one comparator, a running-max register and a beat counter.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_valid, i_data   upstream beat; o_ready says a beat is accepted
//   o_valid, o_data   window maximum; i_ready is downstream acceptance
//
// Build option: define RELU_FUSE_EN to clamp negative results (and -0)
// to +0 on o_data; the running max itself is never altered.
module maxpool_window_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int WINDOW     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready
);

  localparam int CW = $clog2(WINDOW);
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
  localparam int DW = DATA_WIDTH;

  typedef enum logic {
    ACCUM,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   max_q, max_d;
  logic            beat_gt;

  // Sign-magnitude a > b. +0 and -0 compare equal; NaN/Inf are
  // ordered purely by bit pattern.
  function automatic logic gt(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic [DW-2:0] ma;
    logic [DW-2:0] mb;
    ma = a[DW-2:0];
    mb = b[DW-2:0];
    if (ma == '0 && mb == '0)
      gt = 1'b0;
    else if (a[DW-1] != b[DW-1])
      gt = !a[DW-1];
    else if (!a[DW-1])
      gt = ma > mb;
    else
      gt = ma < mb;
  endfunction

  assign beat_gt = gt(i_data, max_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    unique case (state_q)
      ACCUM: begin
        o_ready = 1'b1;
        if (i_valid) begin
          // first beat loads, later beats keep the larger; ties keep old
          if (cnt_q == '0 || beat_gt)
            max_d = i_data;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        o_valid = 1'b1;
        o_ready = i_ready;
        if (i_ready) begin
          state_d = ACCUM;
          // retire and start the next window in the same cycle
          if (i_valid) begin
            max_d = i_data;
            cnt_d = CW'(1);
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
    end
  end

`ifdef RELU_FUSE_EN
  assign o_data = max_q[DW-1] ? '0 : max_q;
`else
  assign o_data = max_q;
`endif

endmodule
